ag32gbd_bram_arb: RTL

Single-port arbiter and sequencer for the 1024×8 camera block RAM. Four requesters share the RAM's one port: register-shadow write, camera compare-matrix read, image-buffer write and image-buffer read. The block also owns the A/B ping-pong buffer select, so that buffer requesters address only 8-bit offsets. It sits between the register, camera and RAM-writer blocks and the BRAM macro, all in the `sys_clock` domain.

---
 rtl/ag32gbd_pkg.sv | 22 ++
 rtl/ag32gbd_rr_pick.sv | 27 ++
 rtl/ag32gbd_bram_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ag32gbd_pkg.sv
// Shared port ids, sequencer states and memory-map constants for the
// ag32gbd camera block-RAM path.
package ag32gbd_pkg;

   typedef enum logic [1:0] {
      P_REG  = 2'd0,
      P_CMP  = 2'd1,
      P_BUFW = 2'd2,
      P_BUFR = 2'd3
   } port_id_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [9:0] BUF_A_BASE = 10'h000;
   localparam logic [9:0] BUF_B_BASE = 10'h100;
   localparam logic [9:0] CMP_BASE   = 10'h200;

endpackage

// File: rtl/ag32gbd_rr_pick.sv
// Three-way round-robin picker for BRAM ports 1..3; ptr holds the port
// number (1..3) searched first, ptr_nxt is one past the granted port.
module ag32gbd_rr_pick (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] ptr_nxt
);

   logic [1:0] start;
   logic [1:0] j;

   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      j       = '0;
      start   = (ptr == 2'd0) ? 2'd0 : ptr - 2'd1;
      for (int k = 0; k < 3; k++) begin
         j = 2'((int'(start) + k) % 3);
         if (gnt == 3'b000 && req[j]) begin
            gnt[j]  = 1'b1;
            ptr_nxt = (j == 2'd2) ? 2'd1 : j + 2'd2;
         end
      end
   end

endmodule

// File: rtl/ag32gbd_bram_arb.sv
// Single-port BRAM arbiter/sequencer: strict-priority register writes,
// round-robin camera/buffer ports with starvation guard, A/B buffer flip.
module ag32gbd_bram_arb
   import ag32gbd_pkg::*;
#(
   parameter int AW         = 10,
   parameter int DW         = 8,
   parameter int STARVE_MAX = 15
) (
   input  logic          sys_clock,
   input  logic          sys_reset,
   input  logic          p0_req,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_ack,
   input  logic          p1_req,
   input  logic [AW-1:0] p1_addr,
   output logic          p1_ack,
   output logic [DW-1:0] p1_rdata,
   input  logic          p2_req,
   input  logic [7:0]    p2_off,
   input  logic [DW-1:0] p2_wdata,
   output logic          p2_ack,
   input  logic          p3_req,
   input  logic [7:0]    p3_off,
   output logic          p3_ack,
   output logic [DW-1:0] p3_rdata,
   input  logic          flip_req,
   output logic          flip_done,
   output logic          front_sel,
   output logic          bram_en,
   output logic          bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_wdata,
   input  logic [DW-1:0] bram_rdata
);

   localparam int SCW = $clog2(STARVE_MAX + 1);

   state_t        state, state_nx;
   port_id_t      lat_port, gnt_port;
   logic          flip_pend, do_flip;
   logic [1:0]    rr_ptr, rr_ptr_nxt, ptr_nx;
   logic [2:0]    rr_gnt;
   logic [SCW-1:0] starve_cnt, starve_nx;
   logic          any_lo, gnt_vld, gnt_we;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_wdata;
   logic [DW-1:0] p1_rdata_q, p3_rdata_q;

   assign any_lo = p1_req | p2_req | p3_req;

   ag32gbd_rr_pick u_rr_pick (
      .req     ({p3_req, p2_req, p1_req}),
      .ptr     (rr_ptr),
      .gnt     (rr_gnt),
      .ptr_nxt (rr_ptr_nxt)
   );

   always_comb begin
      state_nx  = state;
      do_flip   = 1'b0;
      gnt_vld   = 1'b0;
      gnt_port  = P_REG;
      gnt_we    = 1'b0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      starve_nx = starve_cnt;
      ptr_nx    = rr_ptr;
      case (state)
         S_IDLE: begin
            // A flip arriving with a buffer request wins so the request sees the new mapping
            if (flip_pend || flip_req) begin
               do_flip = 1'b1;
            end else if (p0_req && !(any_lo && starve_cnt == SCW'(STARVE_MAX))) begin
               gnt_vld   = 1'b1;
               gnt_port  = P_REG;
               gnt_we    = 1'b1;
               gnt_addr  = p0_addr;
               gnt_wdata = p0_wdata;
               starve_nx = any_lo ? starve_cnt + SCW'(1) : '0;
            end else if (any_lo) begin
               gnt_vld   = 1'b1;
               starve_nx = '0;
               ptr_nx    = rr_ptr_nxt;
               if (rr_gnt[0]) begin
                  gnt_port = P_CMP;
                  gnt_addr = p1_addr;
               end else if (rr_gnt[1]) begin
                  gnt_port  = P_BUFW;
                  gnt_we    = 1'b1;
                  gnt_addr  = (front_sel ? AW'(BUF_A_BASE) : AW'(BUF_B_BASE)) | AW'(p2_off);
                  gnt_wdata = p2_wdata;
               end else begin
                  gnt_port = P_BUFR;
                  gnt_addr = (front_sel ? AW'(BUF_B_BASE) : AW'(BUF_A_BASE)) | AW'(p3_off);
               end
            end
            if (gnt_vld) state_nx = S_ACCESS;
         end
         S_ACCESS: state_nx = S_DONE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state      <= S_IDLE;
         lat_port   <= P_REG;
         flip_pend  <= 1'b0;
         front_sel  <= 1'b0;
         flip_done  <= 1'b0;
         rr_ptr     <= 2'd1;
         starve_cnt <= '0;
         bram_en    <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p2_ack     <= 1'b0;
         p3_ack     <= 1'b0;
         p1_rdata_q <= '0;
         p3_rdata_q <= '0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_nx;
         rr_ptr     <= ptr_nx;
         flip_done  <= do_flip;
         if (do_flip) begin
            front_sel <= ~front_sel;
            flip_pend <= 1'b0;
         end else if (flip_req) begin
            flip_pend <= 1'b1;
         end
         bram_en <= gnt_vld;
         bram_we <= gnt_vld & gnt_we;
         if (gnt_vld) begin
            lat_port   <= gnt_port;
            bram_addr  <= gnt_addr;
            bram_wdata <= gnt_wdata;
         end
         p0_ack <= (state == S_ACCESS) && (lat_port == P_REG);
         p1_ack <= (state == S_ACCESS) && (lat_port == P_CMP);
         p2_ack <= (state == S_ACCESS) && (lat_port == P_BUFW);
         p3_ack <= (state == S_ACCESS) && (lat_port == P_BUFR);
         if (p1_ack) p1_rdata_q <= bram_rdata;
         if (p3_ack) p3_rdata_q <= bram_rdata;
      end
   end

   // BRAM data lands in the ack cycle, so it is forwarded then and held after
   assign p1_rdata = p1_ack ? bram_rdata : p1_rdata_q;
   assign p3_rdata = p3_ack ? bram_rdata : p3_rdata_q;

endmodule
